idex_skid_reg: RTL and testbench

- Parametrised decode-to-execute pipeline register for the multicycle/pipelined processor.
- Replaces the fixed-width enable-only register with a valid/ready handshaked 2-entry skid stage.
- Adds synchronous flush (bubble insertion) and an optional stall-cycle counter.
- Carries PC, both register-file read values, destination register, sign-extended immediate and a control bundle.

---
 rtl/idex_skid_reg.sv | 128 ++++++++++++
 tb/tb_idex_skid_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/idex_skid_reg.sv
// Decode-to-execute pipeline register: valid/ready 2-entry skid stage with synchronous flush.
// Optional stall-cycle counter enabled by defining IDEX_STALL_CNT_EN.
module idex_skid_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CTRLW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rd1,
  input  logic [XLEN-1:0]  in_rd2,
  input  logic [REGW-1:0]  in_rd,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [CTRLW-1:0] in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_srca,
  output logic [XLEN-1:0]  out_srcb,
  output logic [XLEN-1:0]  out_wdata,
  output logic [REGW-1:0]  out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [31:0]      stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [REGW-1:0]  rd;
    logic [XLEN-1:0]  imm;
    logic [CTRLW-1:0] ctrl;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t   state;
  payload_t main_q;
  payload_t skid_q;
  payload_t in_pl;
  logic     acc;
  logic     dq;

  assign in_pl = '{pc: in_pc, rd1: in_rd1, rd2: in_rd2, rd: in_rd, imm: in_imm, ctrl: in_ctrl};
  assign acc   = in_valid & in_ready;
  assign dq    = out_valid & out_ready;

  // Main/skid entry control; in_ready and out_valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      main_q.rd <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            main_q    <= in_pl;
            state     <= BUSY;
            out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (acc && dq) begin
            main_q <= in_pl;
          end else if (acc) begin
            skid_q   <= in_pl;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (dq) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (dq) begin
            main_q   <= skid_q;
            state    <= BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_pc    = main_q.pc;
  assign out_srca  = main_q.rd1;
  assign out_srcb  = main_q.rd2;
  assign out_wdata = main_q.rd2;
  assign out_rd    = main_q.rd;
  assign out_imm   = main_q.imm;
  assign out_ctrl  = main_q.ctrl;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles where execute holds off a valid payload; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_idex_skid_reg.sv
// Self-checking bench for idex_skid_reg: directed vector table, corner sequences, randomized run vs queue model.
module tb_idex_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rd;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_srca, out_srcb, out_wdata, out_imm;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  idex_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_rd(in_rd),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_srca(out_srca), .out_srcb(out_srcb), .out_wdata(out_wdata),
    .out_rd(out_rd), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
  } item_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic        ev;
    logic        er;
    logic [31:0] epc;
    logic [31:0] esrca;
    logic        chk;
  } vec_t;

  // Reference model: an in-order queue of at most two instructions.
  item_t       mq[$];
  logic [31:0] mcnt;
  logic        rd_zero;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic ordy, input item_t it);
    flush = f; in_valid = iv; out_ready = ordy;
    in_pc = it.pc; in_rd1 = it.rd1; in_rd2 = it.rd2;
    in_rd = it.rd; in_imm = it.imm; in_ctrl = it.ctrl;
  endtask

  function automatic item_t mk(input logic [31:0] pc, input logic [31:0] rd1, input logic [4:0] rd);
    item_t it;
    it.pc = pc; it.rd1 = rd1; it.rd2 = rd1 ^ 32'h5A5A_0000; it.rd = rd;
    it.imm = pc + 32'h10; it.ctrl = rd1[7:0] ^ 8'hC3;
    return it;
  endfunction

  function automatic logic cnt_en();
`ifdef IDEX_STALL_CNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: update the model at the edge, then move to the sampling point.
  task automatic step();
    item_t it;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      rd_zero = 1'b1;
    end else begin
      logic rdy;
      rdy = (mq.size() < 2);
      if (mq.size() > 0 && !out_ready && cnt_en() && mcnt != 32'hFFFF_FFFF) mcnt++;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) begin
        it.pc = in_pc; it.rd1 = in_rd1; it.rd2 = in_rd2;
        it.rd = in_rd; it.imm = in_imm; it.ctrl = in_ctrl;
        mq.push_back(it);
        rd_zero = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_check(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    check({tag, "_stall_cnt"}, stall_cnt, mcnt);
    if (mq.size() > 0) begin
      check({tag, "_pc"},    out_pc,    mq[0].pc);
      check({tag, "_srca"},  out_srca,  mq[0].rd1);
      check({tag, "_srcb"},  out_srcb,  mq[0].rd2);
      check({tag, "_wdata"}, out_wdata, mq[0].rd2);
      check({tag, "_rd"},    32'(out_rd),   32'(mq[0].rd));
      check({tag, "_imm"},   out_imm,   mq[0].imm);
      check({tag, "_ctrl"},  32'(out_ctrl), 32'(mq[0].ctrl));
    end else if (rd_zero) begin
      check({tag, "_rd_cleared"}, 32'(out_rd), 32'd0);
    end
  endtask

  task automatic do_reset();
    item_t z;
    z = mk(32'h0, 32'h0, 5'd0);
    drive(1'b0, 1'b0, 1'b0, z);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mcnt = 32'd0;
    rd_zero = 1'b1;
  endtask

  vec_t vec [8];
  item_t nil;

  initial begin
    nil = mk(32'hDEAD_0000, 32'hBEEF, 5'd31);
    vec[0] = '{1'b1, 1'b1, 32'h100, 32'h1, 1'b1, 1'b1, 32'h100, 32'h1, 1'b1};
    vec[1] = '{1'b1, 1'b1, 32'h104, 32'h2, 1'b1, 1'b1, 32'h104, 32'h2, 1'b1};
    vec[2] = '{1'b1, 1'b1, 32'h108, 32'h3, 1'b1, 1'b1, 32'h108, 32'h3, 1'b1};
    vec[3] = '{1'b0, 1'b1, 32'h10C, 32'h4, 1'b0, 1'b1, 32'h0,   32'h0, 1'b0};
    vec[4] = '{1'b1, 1'b0, 32'h300, 32'hA, 1'b1, 1'b1, 32'h300, 32'hA, 1'b1};
    vec[5] = '{1'b1, 1'b0, 32'h304, 32'hB, 1'b1, 1'b0, 32'h300, 32'hA, 1'b1};
    vec[6] = '{1'b0, 1'b1, 32'h308, 32'hC, 1'b1, 1'b1, 32'h304, 32'hB, 1'b1};
    vec[7] = '{1'b0, 1'b1, 32'h30C, 32'hD, 1'b0, 1'b1, 32'h0,   32'h0, 1'b0};

    // Reset release: everything zero, stage ready.
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_pc",    out_pc,    32'd0);
    check("rst_srca",  out_srca,  32'd0);
    check("rst_srcb",  out_srcb,  32'd0);
    check("rst_wdata", out_wdata, 32'd0);
    check("rst_rd",    32'(out_rd), 32'd0);
    check("rst_imm",   out_imm,   32'd0);
    check("rst_ctrl",  32'(out_ctrl), 32'd0);
    check("rst_stall", stall_cnt, 32'd0);

    // Streaming and backpressure table.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, vec[i].iv, vec[i].ordy, mk(vec[i].pc, vec[i].rd1, 5'(i)));
      step();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ev));
      check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vec[i].er));
      if (vec[i].chk) begin
        check($sformatf("vec%0d_pc", i),   out_pc,   vec[i].epc);
        check($sformatf("vec%0d_srca", i), out_srca, vec[i].esrca);
      end
    end

    // Flush while FULL: offered instruction is dropped, out_rd cleared.
    drive(1'b0, 1'b1, 1'b0, mk(32'h400, 32'h11, 5'd7)); step();
    drive(1'b0, 1'b1, 1'b0, mk(32'h404, 32'h12, 5'd3)); step();
    check("flush_pre_in_ready", 32'(in_ready), 32'd0);
    check("flush_pre_rd", 32'(out_rd), 32'd7);
    drive(1'b1, 1'b1, 1'b0, mk(32'h200, 32'h13, 5'd9)); step();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_rd", 32'(out_rd), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b1, nil); step();
    check("flush_post_out_valid", 32'(out_valid), 32'd0);
    check("flush_post_pc_not_200", 32'(out_pc == 32'h200), 32'd0);

    // Asynchronous reset while FULL takes effect before the next edge.
    drive(1'b0, 1'b1, 1'b0, mk(32'h500, 32'h21, 5'd4)); step();
    drive(1'b0, 1'b1, 1'b0, mk(32'h504, 32'h22, 5'd5)); step();
    check("areset_pre_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_in_ready",  32'(in_ready),  32'd1);
    check("areset_pc",    out_pc,   32'd0);
    check("areset_srca",  out_srca, 32'd0);
    check("areset_rd",    32'(out_rd), 32'd0);
    check("areset_stall", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); mcnt = 32'd0; rd_zero = 1'b1;

    // Stall counter: one valid payload held for five edges.
    drive(1'b0, 1'b1, 1'b0, mk(32'h600, 32'h31, 5'd6)); step();
    check("stall_first", stall_cnt, 32'd0);
    drive(1'b0, 1'b0, 1'b0, nil);
    repeat (5) step();
    check("stall_five", stall_cnt, cnt_en() ? 32'd5 : 32'd0);
    check("stall_hold_pc", out_pc, 32'h600);
    drive(1'b1, 1'b0, 1'b0, nil); step();
    check("stall_flush_no_inc", stall_cnt, cnt_en() ? 32'd5 : 32'd0);

    // Randomized run against the queue model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      item_t it;
      it.pc = $urandom(); it.rd1 = $urandom(); it.rd2 = $urandom();
      it.rd = 5'($urandom()); it.imm = $urandom(); it.ctrl = 8'($urandom());
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 5), it);
      step();
      model_check($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
